// File: rtl/wb_vmemem_pkg.sv
// Shared constants for the Wishbone-to-register-block bridge: FSM state encoding
// and the default Done timeout.
package wb_vmemem_pkg;

   localparam int TIMEOUT_DEFAULT = 255;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_WAIT = 3'd1;
   localparam logic [2:0] ST_WR_WAIT = 3'd2;
   localparam logic [2:0] ST_ACK     = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;

endpackage

// File: rtl/wb_vmemem_bridge_if.sv
// Bus bundle of the bridge: Wishbone classic slave side plus the register-block
// request/completion side.
interface wb_vmemem_bridge_if #(
   parameter int AW = 8
);
   // Handshake: a Wishbone request is held on cyc&stb until a one-cycle ack or err;
   // the bridge issues one-cycle Rd/WrMem strobes, and the register block answers each
   // with a one-cycle Done (read data valid with VMERdDone); one request outstanding.
   logic          wb_cyc_i;
   logic          wb_stb_i;
   logic          wb_we_i;
   logic [AW-1:0] wb_adr_i;
   logic [31:0]   wb_dat_i;
   logic [31:0]   wb_dat_o;
   logic          wb_ack_o;
   logic          wb_err_o;
   logic [AW-1:0] VMEAddr;
   logic [31:0]   VMEWrData;
   logic          VMERdMem;
   logic          VMEWrMem;
   logic [31:0]   VMERdData;
   logic          VMERdDone;
   logic          VMEWrDone;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      input  VMERdData, VMERdDone, VMEWrDone,
      output wb_dat_o, wb_ack_o, wb_err_o,
      output VMEAddr, VMEWrData, VMERdMem, VMEWrMem
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      output VMERdData, VMERdDone, VMEWrDone,
      input  wb_dat_o, wb_ack_o, wb_err_o,
      input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem
   );
endinterface

// File: rtl/wb_vmemem_bridge.sv
// Wishbone classic slave to register-block bridge: one outstanding access, a
// saturating Done timeout, and a DRAIN state that absorbs responses to abandoned cycles.
module wb_vmemem_bridge
   import wb_vmemem_pkg::*;
#(
   parameter int AW      = 8,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                Clk,
   input  logic                Rst,
   wb_vmemem_bridge_if.slave   bus,
   output logic [2:0]          o_dbg_state
);

   localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_TO = CW'(TIMEOUT);

   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_is_wr;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wr_data;
   logic [31:0]   r_dat_o;
   logic          r_ack;
   logic          r_err;
   logic          r_rd_mem;
   logic          r_wr_mem;

   logic          w_req;
   logic          w_done;
   logic          w_timeout;

   assign w_req     = bus.wb_cyc_i & bus.wb_stb_i;
   // A Done coinciding with our own strobe cycle cannot belong to this request.
   assign w_done    = ~(r_rd_mem | r_wr_mem) &
                      (r_is_wr ? bus.VMEWrDone : bus.VMERdDone);
   assign w_timeout = (r_cnt == CNT_TO);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_is_wr   <= 1'b0;
         r_addr    <= '0;
         r_wr_data <= '0;
         r_dat_o   <= '0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_rd_mem  <= 1'b0;
         r_wr_mem  <= 1'b0;
      end else begin
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_rd_mem <= 1'b0;
         r_wr_mem <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_addr    <= bus.wb_adr_i;
                  r_wr_data <= bus.wb_dat_i;
                  r_is_wr   <= bus.wb_we_i;
                  r_rd_mem  <= ~bus.wb_we_i;
                  r_wr_mem  <= bus.wb_we_i;
                  r_cnt     <= '0;
                  r_state   <= bus.wb_we_i ? ST_WR_WAIT : ST_RD_WAIT;
               end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
               if (!w_timeout) r_cnt <= r_cnt + CW'(1);
               // Done outranks a timeout reached in the same cycle.
               if (w_done) begin
                  if (!r_is_wr) r_dat_o <= bus.VMERdData;
                  r_ack   <= bus.wb_cyc_i;
                  r_state <= bus.wb_cyc_i ? ST_ACK : ST_IDLE;
               end else if (w_timeout) begin
                  r_err   <= bus.wb_cyc_i;
                  r_state <= bus.wb_cyc_i ? ST_ACK : ST_IDLE;
               end else if (!bus.wb_cyc_i) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_ACK: r_state <= ST_IDLE;
            ST_DRAIN: begin
               if (!w_timeout) r_cnt <= r_cnt + CW'(1);
               if (w_done || w_timeout) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.wb_dat_o  = r_dat_o;
   assign bus.wb_ack_o  = r_ack;
   assign bus.wb_err_o  = r_err;
   assign bus.VMEAddr   = r_addr;
   assign bus.VMEWrData = r_wr_data;
   assign bus.VMERdMem  = r_rd_mem;
   assign bus.VMEWrMem  = r_wr_mem;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_wb_vmemem_bridge.sv
// Bench for wb_vmemem_bridge: directed corner cases then random transactions,
// checked against a transaction-level latency/outcome model.
module tb_wb_vmemem_bridge;
   import wb_vmemem_pkg::*;

   localparam int TO = 16;

   logic        clk;
   logic        rst;
   logic [2:0]  dbg_state;
   int          total = 0;
   int          bad   = 0;
   int          ack_err_both = 0;
   int          rd_wr_both   = 0;
   logic [31:0] model_dat = '0;
   logic [31:0] exp_q[$];

   wb_vmemem_bridge_if #(.AW(8)) bus();

   wb_vmemem_bridge #(.AW(8), .TIMEOUT(TO)) dut (
      .Clk         (clk),
      .Rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   always @(negedge clk) begin
      if (bus.wb_ack_o && bus.wb_err_o) ack_err_both++;
      if (bus.VMERdMem && bus.VMEWrMem) rd_wr_both++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One Wishbone access. d/wd: cycle after the strobe at which the matching /
   // wrong-type Done is pulsed (-1 = never).
   task automatic do_txn(input string tag, input logic we, input logic [7:0] adr,
                         input logic [31:0] dat, input logic [31:0] rdata,
                         input int d, input int wd);
      int          k;
      int          k_term;
      int          n_rd;
      int          n_wr;
      logic        got_ack;
      logic        got_err;
      logic        stable;
      logic        exp_ack;
      int          exp_k;
      logic [31:0] exp_dat;
      logic [31:0] dat_at_term;
      exp_ack = (d >= 1) && (d <= TO);
      exp_k   = exp_ack ? d + 1 : TO + 1;
      exp_dat = (exp_ack && !we) ? rdata : model_dat;
      exp_q.push_back(exp_dat);
      @(negedge clk);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
      bus.wb_adr_i = adr;  bus.wb_dat_i = dat;  bus.VMERdData = rdata;
      k = 0; k_term = -1; n_rd = 0; n_wr = 0;
      got_ack = 1'b0; got_err = 1'b0; stable = 1'b1; dat_at_term = '0;
      while (k_term < 0 && k <= TO + 4) begin
         @(negedge clk);
         n_rd += int'(bus.VMERdMem);
         n_wr += int'(bus.VMEWrMem);
         if (bus.wb_ack_o || bus.wb_err_o) begin
            k_term = k; got_ack = bus.wb_ack_o; got_err = bus.wb_err_o;
            dat_at_term = bus.wb_dat_o;
            bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
            bus.VMERdDone = 1'b0; bus.VMEWrDone = 1'b0;
         end else begin
            if (bus.VMEAddr !== adr || bus.VMEWrData !== dat) stable = 1'b0;
            bus.VMERdDone = we ? (k == wd) : (k == d);
            bus.VMEWrDone = we ? (k == d) : (k == wd);
         end
         k++;
      end
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      bus.VMERdDone = 1'b0; bus.VMEWrDone = 1'b0;
      chk({tag, "_term_cycle"}, k_term, exp_k);
      chk({tag, "_ack"}, got_ack, exp_ack);
      chk({tag, "_err"}, got_err, !exp_ack);
      chk({tag, "_rd_strobes"}, n_rd, we ? 0 : 1);
      chk({tag, "_wr_strobes"}, n_wr, we ? 1 : 0);
      chk({tag, "_addr_data_stable"}, stable, 1'b1);
      chk({tag, "_dat_o"}, dat_at_term, exp_q.pop_front());
      @(negedge clk);
      chk({tag, "_pulse_end"}, {bus.wb_ack_o, bus.wb_err_o}, 2'b00);
      chk({tag, "_back_idle"}, dbg_state, ST_IDLE);
      model_dat = exp_dat;
   endtask

   initial begin
      int          k_ack;
      int          k_str2;
      logic        saw_err;
      logic [31:0] rnd_dat;
      rst = 1'b1;
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
      bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.VMERdData = '0;
      bus.VMERdDone = 0; bus.VMEWrDone = 0;
      repeat (3) @(negedge clk);
      chk("rst_ack_err", {bus.wb_ack_o, bus.wb_err_o}, 2'b00);
      chk("rst_mem_strobes", {bus.VMERdMem, bus.VMEWrMem}, 2'b00);
      chk("rst_dat_o", bus.wb_dat_o, 32'h0);
      chk("rst_addr", bus.VMEAddr, 8'h0);
      chk("rst_wrdata", bus.VMEWrData, 32'h0);
      chk("rst_state", dbg_state, ST_IDLE);
      rst = 1'b0;

      do_txn("rd_min", 1'b0, 8'h00, 32'h0, 32'hDEADBEEF, 1, -1);
      do_txn("wr", 1'b1, 8'h5A, 32'h12345678, 32'h0BADF00D, 3, -1);
      do_txn("timeout", 1'b0, 8'h11, 32'h0, 32'h55555555, -1, -1);
      do_txn("after_timeout", 1'b0, 8'h12, 32'h0, 32'hA5A5A5A5, 2, -1);
      do_txn("race_at_timeout", 1'b0, 8'h13, 32'h0, 32'h13572468, TO, -1);
      do_txn("wr_timeout", 1'b1, 8'h14, 32'hFFFF0000, 32'h0, TO + 1, -1);
      do_txn("rd_wrong_done", 1'b0, 8'h21, 32'h0, 32'h01020304, 5, 2);
      do_txn("wr_wrong_done", 1'b1, 8'h22, 32'h99, 32'h77777777, 4, 1);

      // spurious read Done while idle
      @(negedge clk);
      bus.VMERdData = 32'hFEEDFACE; bus.VMERdDone = 1'b1;
      @(negedge clk);
      bus.VMERdDone = 1'b0;
      @(negedge clk);
      chk("spurious_no_term", {bus.wb_ack_o, bus.wb_err_o}, 2'b00);
      chk("spurious_no_strobe", {bus.VMERdMem, bus.VMEWrMem}, 2'b00);
      chk("spurious_dat_o", bus.wb_dat_o, model_dat);
      chk("spurious_state", dbg_state, ST_IDLE);

      // abort: cyc dropped at strobe+2, master retries at strobe+3, Done at strobe+5
      @(negedge clk);
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = 8'h33;
      @(negedge clk);
      chk("abort_strobe", bus.VMERdMem, 1'b1);
      k_ack = -1; k_str2 = -1; saw_err = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (bus.wb_ack_o && k_ack < 0) k_ack = k;
         if (bus.wb_err_o) saw_err = 1'b1;
         if (bus.VMERdMem && k_str2 < 0) k_str2 = k;
         if (k == 4) chk("abort_drain_state", dbg_state, ST_DRAIN);
         if (k == 2) begin bus.wb_cyc_i = 0; bus.wb_stb_i = 0; end
         if (k == 3) begin bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_adr_i = 8'h34; end
         if (k == 5) bus.VMERdData = 32'h11111111;
         if (k == 8) bus.VMERdData = 32'h24682468;
         bus.VMERdDone = (k == 5) || (k == 8);
         if (k == 9) begin bus.wb_cyc_i = 0; bus.wb_stb_i = 0; end
      end
      chk("abort_second_strobe", k_str2, 7);
      chk("abort_first_ack", k_ack, 9);
      chk("abort_no_err", saw_err, 1'b0);
      chk("abort_retry_dat", bus.wb_dat_o, 32'h24682468);
      model_dat = 32'h24682468;
      @(negedge clk);

      // reset at strobe+1, Done at strobe+2
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0;
      bus.wb_adr_i = 8'h77; bus.wb_dat_i = 32'h87654321;
      @(negedge clk);
      chk("rstmid_strobe", bus.VMERdMem, 1'b1);
      @(negedge clk);
      rst = 1'b1; bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      @(negedge clk);
      chk("rstmid_outputs",
          {29'h0, bus.wb_ack_o, bus.wb_err_o, bus.VMERdMem | bus.VMEWrMem}, 32'h0);
      chk("rstmid_dat_o", bus.wb_dat_o, 32'h0);
      chk("rstmid_addr", bus.VMEAddr, 8'h0);
      chk("rstmid_wrdata", bus.VMEWrData, 32'h0);
      rst = 1'b0; bus.VMERdData = 32'hCAFEF00D; bus.VMERdDone = 1'b1;
      @(negedge clk);
      bus.VMERdDone = 1'b0;
      chk("rstmid_late_done_state", dbg_state, ST_IDLE);
      @(negedge clk);
      chk("rstmid_late_done_ack", bus.wb_ack_o, 1'b0);
      chk("rstmid_late_done_dat", bus.wb_dat_o, 32'h0);
      model_dat = '0;
      do_txn("after_rst", 1'b0, 8'h78, 32'h0, 32'h600DCAFE, 1, -1);

      // random traffic
      for (int n = 0; n < 24; n++) begin
         int d;
         int wd;
         rnd_dat = $urandom;
         d  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, TO + 2));
         wd = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, TO));
         do_txn("rand", 1'($urandom_range(0, 1)), 8'($urandom), rnd_dat,
                $urandom, d, wd);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      chk("never_ack_and_err", ack_err_both, 0);
      chk("never_rd_and_wr_strobe", rd_wr_both, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_vmemem_bridge.md
WB_VMEMEM_BRIDGE -- requirements
Module: wb_vmemem_bridge

Interface
REQ-001 SHALL have parameter AW, default 8, meaning address width of bus and register-block side.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning cycles allowed for a Done before an error.
REQ-003 SHALL have port Clk  in  1  the single clock, with all logic on its rising edge.
REQ-004 SHALL have port Rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic slave request.
REQ-006 SHALL have port wb_adr_i  in  AW  word address.
REQ-007 SHALL have port wb_dat_i  in  32  write data.
REQ-008 SHALL have port wb_dat_o  out  32  read data, registered.
REQ-009 SHALL have ports wb_ack_o, wb_err_o  out  1 each  one-cycle termination pulses.
REQ-010 SHALL have port VMEAddr  out  AW  registered address to the register block.
REQ-011 SHALL have port VMEWrData  out  32  registered write data.
REQ-012 SHALL have ports VMERdMem, VMEWrMem  out  1 each  one-cycle request strobes.
REQ-013 SHALL have port VMERdData  in  32  register-block read data, valid when VMERdDone=1.
REQ-014 SHALL have ports VMERdDone, VMEWrDone  in  1 each  completion pulses from the register block.

Function
REQ-015 SHALL implement FSM states IDLE, RD_WAIT, WR_WAIT, ACK, DRAIN.
REQ-016 In IDLE with cyc&stb at cycle T, SHALL latch adr/dat, pulse VMERdMem (we=0) or VMEWrMem (we=1) at T+1, and enter RD_WAIT or WR_WAIT.
REQ-017 SHALL keep VMEAddr/VMEWrData stable from strobe until leaving the WAIT state.
REQ-018 In RD_WAIT, VMERdDone at cycle D SHALL capture VMERdData into wb_dat_o, pulse wb_ack_o at D+1 (ACK state), and return to IDLE at D+2.
REQ-019 In WR_WAIT, VMEWrDone SHALL behave as REQ-018, except that wb_dat_o holds its previous value.
REQ-020 Done SHALL be accepted in any cycle from strobe+1 onward, so minimum latency is stb-to-ack 3 cycles.
REQ-021 SHALL ignore Done pulses of the wrong type (e.g. VMEWrDone in RD_WAIT) and Done pulses arriving in IDLE or ACK.
REQ-022 SHALL count a wait counter from 0 at strobe; if it reaches TIMEOUT without Done, it SHALL pulse wb_err_o (no ack) via ACK and return to IDLE.
REQ-023 A Done pulse in the same cycle the counter reaches TIMEOUT SHALL win: the block acks and does not error.
REQ-024 If wb_cyc_i drops in a WAIT state, SHALL enter DRAIN with no ack/err, and stay there until matching Done or TIMEOUT, then go to IDLE.
REQ-025 SHALL never issue a new strobe while in WAIT, ACK or DRAIN, so at most one request is outstanding.
REQ-026 SHALL never assert wb_ack_o and wb_err_o in the same cycle.
REQ-027 SHALL never assert VMERdMem and VMEWrMem in the same cycle.
REQ-028 The wait counter SHALL be ceil(log2(TIMEOUT+1)) bits wide and SHALL saturate, never wrap.

Reset
REQ-029 Rst=1 SHALL force IDLE and clear the counter.
REQ-030 Rst=1 SHALL drive wb_ack_o=0, wb_err_o=0, VMERdMem=0 and VMEWrMem=0.
REQ-031 Rst=1 SHALL drive wb_dat_o=0, VMEAddr=0 and VMEWrData=0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction, and a Done arriving after reset release SHALL be ignored per REQ-021.

Structure
REQ-033 The FSM state enumeration and the default TIMEOUT constant SHALL reside in a shared package, wb_vmemem_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-035 Read: adr=0x00, register block returning 0xDEADBEEF with Done at strobe+1 -> wb_ack_o at stb+3, wb_dat_o=0xDEADBEEF.
REQ-036 Write: dat=0x12345678 -> single VMEWrMem pulse with VMEWrData=0x12345678, ack after VMEWrDone, no VMERdMem.
REQ-037 Timeout: TIMEOUT=16, no Done -> wb_err_o one cycle at strobe+17, no ack; then a fresh read completes normally.
REQ-038 Abort: cyc dropped 2 cycles after strobe, Done at strobe+5 -> no ack/err, DRAIN until Done, and next request strobes only after that.
REQ-039 Spurious/race: VMERdDone pulsed in IDLE -> no response; Done exactly at the TIMEOUT cycle -> ack, not err.
REQ-040 Reset mid-read: Rst at strobe+1, Done at strobe+2 -> all outputs 0, no ack, and the block is idle-ready.
